// File: rtl/shift_tx.sv
// Parallel-to-serial transmitter: sends a DW-bit word LSB first, holding each bit DIV clocks.
// Define SHIFT_TX_PARITY_EN to append an even-parity bit after the MSB.
module shift_tx #(
    parameter int DW  = 8,
    parameter int DIV = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tx_start,
    input  logic [DW-1:0] din,
    output logic          tx_ready,
    output logic          sout,
    output logic          sout_en,
    output logic          tx_done_tick
);

`ifdef SHIFT_TX_PARITY_EN
    localparam int NBITS = DW + 1;
`else
    localparam int NBITS = DW;
`endif
    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(NBITS);
    localparam logic [TW-1:0] TICK_MAX = TW'(DIV - 1);
    localparam logic [BW-1:0] BIT_MAX  = BW'(NBITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t           state_q, state_d;
    logic [NBITS-1:0] shreg_q, shreg_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [NBITS-1:0] loadWord;

`ifdef SHIFT_TX_PARITY_EN
    assign loadWord = {^din, din};
`else
    assign loadWord = din;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            tick_q  <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
        end
    end

    // The tick counter is reused in GAP so the gap also spans DIV cycles.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        tick_d       = tick_q;
        bit_d        = bit_q;
        tx_ready     = 1'b0;
        sout         = 1'b0;
        sout_en      = 1'b0;
        tx_done_tick = 1'b0;
        case (state_q)
            IDLE: begin
                tx_ready = 1'b1;
                if (tx_start) begin
                    shreg_d = loadWord;
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sout    = shreg_q[0];
                sout_en = 1'b1;
                if (tick_q == TICK_MAX) begin
                    tick_d  = '0;
                    shreg_d = shreg_q >> 1;
                    if (bit_q == BIT_MAX) begin
                        bit_d   = '0;
                        state_d = GAP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            GAP: begin
                tx_done_tick = (tick_q == '0);
                if (tick_q == TICK_MAX) begin
                    tick_d  = '0;
                    state_d = IDLE;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/shift_tx.md
SHIFT_TX -- requirements
Module: shift_tx

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning data word width in bits (DW >= 2).
REQ-002 The block SHALL have parameter DIV, default 4, meaning clock cycles each serial bit is held (DIV >= 1).
REQ-003 The block SHALL have port clk  input  1  the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port tx_start  input  1  request to transmit din.
REQ-006 The block SHALL have port din  input  DW  parallel word to serialize.
REQ-007 The block SHALL have port tx_ready  output  1  high when a tx_start will be accepted.
REQ-008 The block SHALL have port sout  output  1  serial data, LSB first.
REQ-009 The block SHALL have port sout_en  output  1  high while sout carries a valid bit.
REQ-010 The block SHALL have port tx_done_tick  output  1  one-cycle pulse marking the end of a word.

Function
REQ-011 The block SHALL use an FSM with states IDLE, SHIFT and GAP.
REQ-012 In IDLE, tx_ready SHALL be 1; in SHIFT and GAP, tx_ready SHALL be 0.
REQ-013 On a rising edge with state IDLE and tx_start=1, the block SHALL load din into a shift register, clear the tick and bit counters, and enter SHIFT.
REQ-014 tx_start SHALL be ignored in SHIFT and GAP, and din SHALL be sampled only at acceptance.
REQ-015 In SHIFT, sout SHALL equal the shift-register LSB, and sout_en SHALL be 1.
REQ-016 Each bit SHALL be held for exactly DIV cycles, after which the register shifts right by one.
REQ-017 After the last bit's DIV cycles, the FSM SHALL enter GAP, and tx_done_tick SHALL be 1 for exactly the first GAP cycle.
REQ-018 GAP SHALL last DIV cycles with sout=0 and sout_en=0, then the FSM SHALL return to IDLE.
REQ-019 Outside SHIFT, sout SHALL be 0 and sout_en SHALL be 0.
REQ-020 The first valid bit SHALL appear in the cycle after the accepting edge, giving a latency of 1 cycle.
REQ-021 tx_ready SHALL reassert exactly (NBITS+1)*DIV cycles after the accepting edge, where NBITS = DW, or DW+1 with parity enabled.
REQ-022 The counters SHALL be sized to hold DIV-1 and NBITS-1 without overflow, and SHALL wrap only by explicit clear.
REQ-023 A tx_start held continuously SHALL start a new word on the first IDLE cycle, giving a back-to-back period of (NBITS+1)*DIV+1 cycles.

Reset
REQ-024 Reset=1 SHALL force state IDLE, counters 0, shift register 0, tx_ready=1, sout=0, sout_en=0 and tx_done_tick=0, immediately and without waiting for clk.
REQ-025 Reset asserted mid-word SHALL abort the word with no tx_done_tick, and the first accept after deassertion SHALL behave as REQ-013.

Configuration
REQ-026 Macro SHIFT_TX_PARITY_EN defined: at acceptance, the block SHALL compute an even-parity bit over din and send it as bit DW (after the MSB), giving NBITS=DW+1.
REQ-027 Macro SHIFT_TX_PARITY_EN undefined: no parity logic SHALL exist, and NBITS=DW.

Verification
REQ-028 Scenario: DW=8, DIV=4, no parity, din=8'hA5 with a one-cycle tx_start -> sout=1,0,1,0,0,1,0,1, each held 4 cycles; sout_en high 32 cycles; tx_done_tick at cycle 33; tx_ready back at cycle 36.
REQ-029 Scenario: parity enabled, din=8'h07 -> 8 data bits then parity=1, sout_en high 36 cycles, tx_ready back at cycle 40; with din=8'hA5, parity bit=0.
REQ-030 Scenario: tx_start pulsed with din=8'hFF during SHIFT of an 8'h00 word -> sout stays 0 all 32 cycles, and no extra word is sent.
REQ-031 Scenario: tx_start held high with din=8'h3C -> words start every 37 cycles, with tx_done_tick once per word.
REQ-032 Scenario: reset asserted asynchronously at cycle 10 of a word -> outputs take reset values before the next edge, and no tx_done_tick occurs.
REQ-033 Scenario: DIV=1, din=8'h81 -> each bit held 1 cycle, and tx_ready returns 9 cycles after acceptance.
